ahb_sub_ram: RTL
================

// Module: ahb_sub_ram
// PURPOSE
//  AHB-Lite subordinate (responder end of the manager bus) fronting a word-addressed RAM.
//  Sits behind the uncore address decoder.
//  Accepts single and burst transfers, inserts a programmable number of wait states,
//  applies byte strobes on writes and returns two-cycle ERROR for illegal accesses.
// PARAMETERS
//  PA_BITS      52  physical address width on HADDR
//  AHBW         32  data bus width (32 or 64)
//  DEPTH      1024  RAM depth in AHBW-bit words (power of 2)
//  BASE          0  byte base address of this region (aligned to DEPTH*AHBW/8)
//  WAIT_STATES   0  wait cycles inserted before each OKAY completion (0..15)
// PORTS
//  HCLK       in   1          bus clock, all state on rising edge
//  HRESET     in   1          asynchronous, active-high reset
//  HSEL       in   1          decoder select for this subordinate
//  HADDR      in   PA_BITS    byte address (address phase)
//  HWRITE     in   1          1=write 0=read (address phase)
//  HSIZE      in   3          transfer size, log2 bytes (address phase)
//  HBURST     in   3          burst type (ignored; each beat handled as single)
//  HPROT      in   4          protection (ignored)
//  HTRANS     in   2          IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HMASTLOCK  in   1          lock (ignored)
//  HREADY     in   1          bus-level ready (mux of all HREADYOUTs)
//  HWDATA     in   AHBW       write data (data phase)
//  HWSTRB     in   AHBW/8     byte write strobes (data phase)
//  HREADYOUT  out  1          this subordinate's ready
//  HRESP      out  1          0=OKAY 1=ERROR
//  HRDATA     out  AHBW       read data (data phase)
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0.
//   RAM contents not cleared; a write whose data phase is interrupted by reset is not committed.
//  Accept: addr phase valid when HSEL & HREADY & HTRANS[1]; latch HADDR, HWRITE, HSIZE.
//   IDLE/BUSY, or HSEL=0 while HREADY=1: no access, next cycle OKAY zero-wait.
//  Legality check at accept: error if
//   - HADDR outside [BASE, BASE+DEPTH*AHBW/8), or
//   - HSIZE > log2(AHBW/8), or
//   - HADDR not aligned to 2^HSIZE.
//  States:
//   IDLE  - HREADYOUT=1, HRESP=0. Legal accept, WAIT_STATES>0: ->WAIT (cnt=WAIT_STATES-1).
//           Legal, WAIT_STATES=0: ->DATA. Illegal: ->ERR1.
//   WAIT  - HREADYOUT=0, HRESP=0. cnt decrements; at cnt==0 ->DATA.
//   DATA  - HREADYOUT=1, HRESP=0. Access completes this cycle.
//           Read: HRDATA=mem[addr_q word index]. Write: each byte i with HWSTRB[i]=1 takes
//           HWDATA byte i into mem at clock edge. Pipelined next accept in same cycle follows
//           IDLE rules; otherwise ->IDLE.
//   ERR1  - HREADYOUT=0, HRESP=1. Always ->ERR2.
//   ERR2  - HREADYOUT=1, HRESP=1. No RAM access. Next accept (manager may cancel with IDLE)
//           follows IDLE rules.
//  HRDATA = 0 in every state except a read in DATA.
//  Latency: OKAY completes WAIT_STATES+1 cycles after the address phase.
//  Back-to-back write then read of same word: read returns the newly written bytes
//   (write commits at end of write data phase, before read data phase).
//  Address phase is sampled only when HREADY=1; while HREADYOUT=0 bus inputs are ignored.
//  HBURST, HPROT, HMASTLOCK accepted but have no effect.
//  Word index = (HADDR-BASE)>>log2(AHBW/8); sub-word reads return the full word.
//   Manager selects lanes.
// TESTING
//  1 WAIT_STATES=0: NONSEQ write 0xDEADBEEF @BASE+4 strb=1111, then read @BASE+4
//    -> HRDATA=0xDEADBEEF, HREADYOUT=1 in each data phase.
//  2 WAIT_STATES=2: read -> HREADYOUT low 2 cycles then high with data, HRESP=0 throughout.
//  3 Byte write 0x000000AA strb=0001 over word 0x11223344 -> readback 0x112233AA.
//  4 Address BASE+DEPTH*4 -> cycle1 {HREADYOUT=0,HRESP=1}, cycle2 {1,1}; RAM unchanged.
//  5 HSIZE=2 at BASE+2 (misaligned) -> two-cycle ERROR; HTRANS=BUSY or HSEL=0 -> OKAY,
//    zero-wait, no RAM change.
//  6 Assert HRESET during WAIT of a write -> HREADYOUT=1, HRESP=0 immediately;
//    target word unchanged on later read.

Source files
------------

// File: rtl/ahb_sub_ram.sv
// AHB-Lite subordinate fronting a word-addressed RAM with byte strobes, a programmable number of
// wait states and a two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
module ahb_sub_ram #(
    parameter int unsigned     PA_BITS     = 52,
    parameter int unsigned     AHBW        = 32,
    parameter int unsigned     DEPTH       = 1024,
    parameter longint unsigned BASE        = 0,
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic                HSEL,
    input  logic [PA_BITS-1:0]  HADDR,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [2:0]          HBURST,
    input  logic [3:0]          HPROT,
    input  logic [1:0]          HTRANS,
    input  logic                HMASTLOCK,
    input  logic                HREADY,
    input  logic [AHBW-1:0]     HWDATA,
    input  logic [AHBW/8-1:0]   HWSTRB,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [AHBW-1:0]     HRDATA
);

    localparam int unsigned BYTES  = AHBW / 8;
    localparam int unsigned SZ_MAX = $clog2(BYTES);
    localparam int unsigned AW     = $clog2(DEPTH);

    localparam logic [PA_BITS-1:0] BASE_A   = PA_BITS'(BASE);
    localparam logic [PA_BITS-1:0] SPAN     = PA_BITS'(DEPTH * BYTES);
    localparam logic [3:0]         CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               write_q, write_d;
    logic               accept, legal;
    logic [PA_BITS-1:0] offset;
    logic [7:0]         align_mask;
    logic [AHBW-1:0]    mem [DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign offset     = HADDR - BASE_A;
    assign align_mask = (8'd1 << HSIZE) - 8'd1;
    // offset wraps for addresses below BASE, so the lower bound is checked separately
    assign legal = (HADDR >= BASE_A) && (offset < SPAN) && (HSIZE <= 3'(SZ_MAX)) &&
                   ((HADDR[7:0] & align_mask) == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        case (state_q)
            StWait: begin
                if (cnt_q == 4'd0) state_d = StData;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StErr1: state_d = StErr2;
            default: begin
                // Idle, the last data cycle and the second error cycle all accept a new request
                state_d = StIdle;
                if (accept) begin
                    idx_d   = offset[AW+SZ_MAX-1:SZ_MAX];
                    write_d = HWRITE;
                    if (!legal) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = StData;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
        end
    end

    // Reset forces the state out of StData, so an interrupted write never commits
    always_ff @(posedge HCLK) begin
        if (state_q == StData && write_q) begin
            for (int i = 0; i < BYTES; i++) begin
                if (HWSTRB[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
        HRESP     = (state_q == StErr1) || (state_q == StErr2);
        HRDATA    = '0;
        if (state_q == StData && !write_q) HRDATA = mem[idx_q];
    end

endmodule
